// File: rtl/fc_pe4_feeder.sv
// Sequencer feeding one 4-column FC systolic row: clear, skewed stream, drain, collect result.
// Optional drain watchdog enabled by defining FC_FEEDER_TIMEOUT_EN.
module fc_pe4_feeder #(
  parameter int unsigned LEN_W   = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [31:0]      bias_in,
  output logic             busy,
  output logic             act_rd,
  output logic [LEN_W-1:0] act_addr,
  input  logic [7:0]       act_rdata,
  output logic             w_rd,
  output logic [LEN_W-1:0] w_addr,
  input  logic [31:0]      w_rdata,
  output logic             pe_clr_n,
  output logic [7:0]       pe_a,
  output logic             pe_fin,
  output logic [7:0]       pe_b1,
  output logic [7:0]       pe_b2,
  output logic [7:0]       pe_b3,
  output logic [7:0]       pe_b4,
  output logic [31:0]      pe_bias,
  input  logic [31:0]      pe_result,
  input  logic             pe_done,
  output logic [31:0]      result,
  output logic             result_valid,
  output logic             error
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [31:0]      pe_bias_q, pe_bias_d;
  logic [LEN_W-1:0] addr_q, addr_d;
  logic             rd_q, rd_d;
  logic             last_q, last_d;
  logic             rd_dly_q, rd_dly_d;
  logic             last_dly_q, last_dly_d;
  logic [7:0]       pe_a_q, pe_a_d;
  logic             pe_fin_q, pe_fin_d;
  logic [7:0]       pe_b1_q, pe_b1_d;
  logic [7:0]       b2_s1_q, b2_s1_d;
  logic [7:0]       pe_b2_q, pe_b2_d;
  logic [7:0]       b3_s1_q, b3_s1_d;
  logic [7:0]       b3_s2_q, b3_s2_d;
  logic [7:0]       pe_b3_q, pe_b3_d;
  logic [7:0]       b4_s1_q, b4_s1_d;
  logic [7:0]       b4_s2_q, b4_s2_d;
  logic [7:0]       b4_s3_q, b4_s3_d;
  logic [7:0]       pe_b4_q, pe_b4_d;
  logic             done_prev_q, done_prev_d;
  logic [31:0]      result_q, result_d;
  logic             result_valid_q, result_valid_d;
  logic             busy_q, busy_d;
  logic             pe_clr_n_q, pe_clr_n_d;
  logic             done_rise;

`ifdef FC_FEEDER_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  logic [TO_W-1:0] drain_cnt_q, drain_cnt_d;
  logic            error_q, error_d;
`else
  logic unused_timeout;
  assign unused_timeout = 1'(TIMEOUT % 2);
`endif

  assign done_rise = pe_done & ~done_prev_q;

  // Next-state, counters and the skew pipeline; the pipeline shifts every cycle and
  // carries zeros outside the valid window, so it drains on its own after FEED.
  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    pe_bias_d      = pe_bias_q;
    addr_d         = '0;
    rd_d           = 1'b0;
    last_d         = 1'b0;
    rd_dly_d       = rd_q;
    last_dly_d     = rd_q & last_q;
    pe_a_d         = rd_dly_q ? act_rdata : 8'h00;
    pe_fin_d       = rd_dly_q & last_dly_q;
    pe_b1_d        = rd_dly_q ? w_rdata[31:24] : 8'h00;
    b2_s1_d        = rd_dly_q ? w_rdata[23:16] : 8'h00;
    pe_b2_d        = b2_s1_q;
    b3_s1_d        = rd_dly_q ? w_rdata[15:8] : 8'h00;
    b3_s2_d        = b3_s1_q;
    pe_b3_d        = b3_s2_q;
    b4_s1_d        = rd_dly_q ? w_rdata[7:0] : 8'h00;
    b4_s2_d        = b4_s1_q;
    b4_s3_d        = b4_s2_q;
    pe_b4_d        = b4_s3_q;
    done_prev_d    = pe_done;
    result_d       = result_q;
    result_valid_d = 1'b0;
    busy_d         = 1'b0;
    pe_clr_n_d     = 1'b1;
`ifdef FC_FEEDER_TIMEOUT_EN
    drain_cnt_d    = '0;
    error_d        = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (start && (len != '0)) begin
          state_d   = S_CLEAR;
          len_d     = len;
          pe_bias_d = bias_in;
        end
      end
      S_CLEAR: begin
        state_d = S_FEED;
        addr_d  = '0;
        rd_d    = 1'b1;
        last_d  = (len_q == LEN_W'(1));
      end
      S_FEED: begin
        if (addr_q == len_q - LEN_W'(1)) begin
          state_d = S_DRAIN;
        end else begin
          addr_d = addr_q + LEN_W'(1);
          rd_d   = 1'b1;
          last_d = (addr_d == len_q - LEN_W'(1));
        end
      end
      S_DRAIN: begin
        if (done_rise) begin
          state_d  = S_DONE;
          result_d = pe_result;
        end
`ifdef FC_FEEDER_TIMEOUT_EN
        else if (drain_cnt_q == TO_W'(TIMEOUT - 1)) begin
          state_d = S_IDLE;
          error_d = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q + TO_W'(1);
        end
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Control outputs are registered from the next state so they line up with it.
    result_valid_d = (state_d == S_DONE);
    busy_d         = (state_d != S_IDLE);
    pe_clr_n_d     = (state_d != S_CLEAR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      len_q          <= '0;
      pe_bias_q      <= '0;
      addr_q         <= '0;
      rd_q           <= 1'b0;
      last_q         <= 1'b0;
      rd_dly_q       <= 1'b0;
      last_dly_q     <= 1'b0;
      pe_a_q         <= '0;
      pe_fin_q       <= 1'b0;
      pe_b1_q        <= '0;
      b2_s1_q        <= '0;
      pe_b2_q        <= '0;
      b3_s1_q        <= '0;
      b3_s2_q        <= '0;
      pe_b3_q        <= '0;
      b4_s1_q        <= '0;
      b4_s2_q        <= '0;
      b4_s3_q        <= '0;
      pe_b4_q        <= '0;
      done_prev_q    <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      pe_clr_n_q     <= 1'b0;
`ifdef FC_FEEDER_TIMEOUT_EN
      drain_cnt_q    <= '0;
      error_q        <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      pe_bias_q      <= pe_bias_d;
      addr_q         <= addr_d;
      rd_q           <= rd_d;
      last_q         <= last_d;
      rd_dly_q       <= rd_dly_d;
      last_dly_q     <= last_dly_d;
      pe_a_q         <= pe_a_d;
      pe_fin_q       <= pe_fin_d;
      pe_b1_q        <= pe_b1_d;
      b2_s1_q        <= b2_s1_d;
      pe_b2_q        <= pe_b2_d;
      b3_s1_q        <= b3_s1_d;
      b3_s2_q        <= b3_s2_d;
      pe_b3_q        <= pe_b3_d;
      b4_s1_q        <= b4_s1_d;
      b4_s2_q        <= b4_s2_d;
      b4_s3_q        <= b4_s3_d;
      pe_b4_q        <= pe_b4_d;
      done_prev_q    <= done_prev_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      busy_q         <= busy_d;
      pe_clr_n_q     <= pe_clr_n_d;
`ifdef FC_FEEDER_TIMEOUT_EN
      drain_cnt_q    <= drain_cnt_d;
      error_q        <= error_d;
`endif
    end
  end

  assign busy         = busy_q;
  assign act_rd       = rd_q;
  assign act_addr     = addr_q;
  assign w_rd         = rd_q;
  assign w_addr       = addr_q;
  assign pe_clr_n     = pe_clr_n_q;
  assign pe_a         = pe_a_q;
  assign pe_fin       = pe_fin_q;
  assign pe_b1        = pe_b1_q;
  assign pe_b2        = pe_b2_q;
  assign pe_b3        = pe_b3_q;
  assign pe_b4        = pe_b4_q;
  assign pe_bias      = pe_bias_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
`ifdef FC_FEEDER_TIMEOUT_EN
  assign error        = error_q;
`else
  assign error        = 1'b0;
`endif

endmodule

// File: tb/tb_fc_pe4_feeder.sv
// Directed bench for fc_pe4_feeder: buffer model plus hand-computed per-cycle expectations.
module tb_fc_pe4_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic [31:0] bias_in;
  logic        busy;
  logic        act_rd;
  logic [7:0]  act_addr;
  logic [7:0]  act_rdata;
  logic        w_rd;
  logic [7:0]  w_addr;
  logic [31:0] w_rdata;
  logic        pe_clr_n;
  logic [7:0]  pe_a;
  logic        pe_fin;
  logic [7:0]  pe_b1, pe_b2, pe_b3, pe_b4;
  logic [31:0] pe_bias;
  logic [31:0] pe_result;
  logic        pe_done;
  logic [31:0] result;
  logic        result_valid;
  logic        error;

  logic [7:0]  act_mem [256];
  logic [31:0] w_mem   [256];

  int n_vec = 0;
  int n_err = 0;

  fc_pe4_feeder #(.LEN_W(8), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .bias_in(bias_in), .busy(busy),
    .act_rd(act_rd), .act_addr(act_addr), .act_rdata(act_rdata),
    .w_rd(w_rd), .w_addr(w_addr), .w_rdata(w_rdata),
    .pe_clr_n(pe_clr_n), .pe_a(pe_a), .pe_fin(pe_fin),
    .pe_b1(pe_b1), .pe_b2(pe_b2), .pe_b3(pe_b3), .pe_b4(pe_b4),
    .pe_bias(pe_bias), .pe_result(pe_result), .pe_done(pe_done),
    .result(result), .result_valid(result_valid), .error(error)
  );

  always #5 clk = ~clk;

  // Synchronous activation/weight buffers: data one cycle after the read strobe.
  always @(posedge clk) begin
    if (act_rd) act_rdata <= act_mem[act_addr];
    if (w_rd)   w_rdata   <= w_mem[w_addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic launch(input logic [7:0] l, input logic [31:0] b);
    start = 1'b1; len = l; bias_in = b;
    tick();
    start = 1'b0; len = 8'h00;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctl"}, 64'({busy, act_rd, w_rd, pe_clr_n, pe_fin, result_valid, error}), 64'h0);
    chk({tag, "_addr"}, 64'({act_addr, w_addr}), 64'h0);
    chk({tag, "_pe"}, 64'({pe_a, pe_b1, pe_b2, pe_b3, pe_b4}), 64'h0);
    chk({tag, "_bias"}, 64'(pe_bias), 64'h0);
    chk({tag, "_res"}, 64'(result), 64'h0);
  endtask

  // Called in DRAIN with pe_done low in the previous cycle.
  task automatic finish_run(input string tag, input logic [31:0] r);
    pe_result = r; pe_done = 1'b1;
    tick();
    chk({tag, "_valid"}, 64'({busy, result_valid}), 64'h3);
    chk({tag, "_result"}, 64'(result), 64'(r));
    pe_done = 1'b0;
    tick();
    chk({tag, "_idle"}, 64'({busy, result_valid}), 64'h0);
  endtask

  function automatic logic [63:0] stream_obs();
    return 64'({pe_fin, pe_a, pe_b1, pe_b2, pe_b3, pe_b4});
  endfunction

  initial begin
    logic [7:0] ea, e1, e2, e3, e4;
    logic       ef, erd;
    logic [7:0] eaddr;
    int         rd_cnt, bad, last_addr;

    rst = 1'b1; start = 1'b0; len = 8'h00; bias_in = 32'h0;
    pe_result = 32'h0; pe_done = 1'b0;
    for (int i = 0; i < 256; i++) begin
      act_mem[i] = 8'(i); w_mem[i] = 32'h0;
    end

    // Reset state
    repeat (3) tick();
    check_zero("rst");
    rst = 1'b0;
    tick();
    chk("rst_clr_n_release", 64'({pe_clr_n, busy}), 64'h2);

    // Test 1: len=4 skewed stream
    for (int i = 0; i < 4; i++) begin
      act_mem[i] = 8'(i + 1); w_mem[i] = 32'h01020304;
    end
    launch(8'd4, 32'hCAFE0001);
    chk("t1_clear", 64'({pe_clr_n, busy}), 64'h1);
    chk("t1_bias", 64'(pe_bias), 64'hCAFE0001);
    for (int n = 1; n <= 12; n++) begin
      ea  = (n >= 4 && n <= 7) ? 8'(n - 3) : 8'h00;
      e1  = (n >= 4 && n <= 7)  ? 8'd1 : 8'd0;
      e2  = (n >= 5 && n <= 8)  ? 8'd2 : 8'd0;
      e3  = (n >= 6 && n <= 9)  ? 8'd3 : 8'd0;
      e4  = (n >= 7 && n <= 10) ? 8'd4 : 8'd0;
      ef  = (n == 7);
      erd = (n >= 2 && n <= 5);
      eaddr = erd ? 8'(n - 2) : 8'h00;
      chk($sformatf("t1_stream_c%0d", n), stream_obs(), 64'({ef, ea, e1, e2, e3, e4}));
      chk($sformatf("t1_addr_c%0d", n), 64'({act_rd, w_rd, act_addr, w_addr}),
          64'({erd, erd, eaddr, eaddr}));
      tick();
    end

    // Test 2: pe_done rises 6 cycles after pe_fin
    chk("t2_drain", 64'({busy, result_valid}), 64'h2);
    pe_result = 32'h11223344; pe_done = 1'b1;
    tick();
    chk("t2_valid", 64'({busy, result_valid}), 64'h3);
    chk("t2_result", 64'(result), 64'h11223344);
    chk("t2_bias_hold", 64'(pe_bias), 64'hCAFE0001);
    tick();
    chk("t2_idle", 64'({busy, result_valid}), 64'h0);
    chk("t2_result_hold", 64'(result), 64'h11223344);

    // Test 3: pe_done still high from prior run
    act_mem[0] = 8'h05; act_mem[1] = 8'h06;
    w_mem[0] = 32'h10203040; w_mem[1] = 32'h10203040;
    launch(8'd2, 32'h0BADBEEF);
    chk("t3_clear", 64'(pe_clr_n), 64'h0);
    tick();
    chk("t3_clear_1cyc", 64'(pe_clr_n), 64'h1);
    for (int n = 2; n <= 14; n++) begin
      chk($sformatf("t3_hold_c%0d", n), 64'({error, result_valid, result}), 64'h11223344);
      if (n < 14) tick();
    end
    pe_done = 1'b0;
    tick();
    chk("t3_fall", 64'({busy, result_valid}), 64'h2);
    finish_run("t3", 32'hA5A50F0F);

    // Test 4: len=1
    act_mem[0] = 8'h80; w_mem[0] = 32'h7F7F7F7F;
    launch(8'd1, 32'h0);
    for (int n = 1; n <= 10; n++) begin
      ea = (n == 4) ? 8'h80 : 8'h00;
      e1 = (n == 4) ? 8'h7F : 8'h00;
      e2 = (n == 5) ? 8'h7F : 8'h00;
      e3 = (n == 6) ? 8'h7F : 8'h00;
      e4 = (n == 7) ? 8'h7F : 8'h00;
      ef = (n == 4);
      chk($sformatf("t4_stream_c%0d", n), stream_obs(), 64'({ef, ea, e1, e2, e3, e4}));
      tick();
    end
    finish_run("t4", 32'h01020304);

    // Test 5: start during FEED ignored; start with len=0 ignored
    for (int i = 0; i < 4; i++) act_mem[i] = 8'(i + 9);
    launch(8'd4, 32'h0);
    for (int n = 1; n <= 8; n++) begin
      erd = (n >= 2 && n <= 5);
      eaddr = erd ? 8'(n - 2) : 8'h00;
      chk($sformatf("t5_addr_c%0d", n), 64'({act_rd, act_addr}), 64'({erd, eaddr}));
      if (n == 3) begin start = 1'b1; len = 8'd7; end
      else begin start = 1'b0; len = 8'd0; end
      tick();
    end
    finish_run("t5", 32'h00000055);
    start = 1'b1; len = 8'd0;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 3; n++) begin
      chk($sformatf("t5_len0_c%0d", n), 64'({busy, act_rd, pe_clr_n}), 64'h1);
      tick();
    end

    // Boundary: len=255 addresses 0..254 without wrap
    launch(8'd255, 32'h0);
    tick();
    rd_cnt = 0; bad = 0; last_addr = -1;
    for (int n = 2; n <= 257; n++) begin
      if (act_rd) begin
        if (int'(act_addr) != n - 2) bad++;
        rd_cnt++;
        last_addr = int'(act_addr);
      end
      if (n < 257) tick();
    end
    chk("tmax_rd_count", 64'(rd_cnt), 64'd255);
    chk("tmax_addr_errs", 64'(bad), 64'd0);
    chk("tmax_last_addr", 64'(last_addr), 64'd254);
    chk("tmax_after", 64'({act_rd, act_addr}), 64'h0);
    finish_run("tmax", 32'hDEADBEEF);

    // Test 6: reset in FEED at k=2
    for (int i = 0; i < 4; i++) act_mem[i] = 8'(i + 1);
    launch(8'd4, 32'h12345678);
    tick(); tick(); tick();
    chk("t6_k2", 64'({act_rd, act_addr}), 64'h102);
    rst = 1'b1;
    tick();
    check_zero("t6_rst");
    rst = 1'b0;
    tick();
    chk("t6_release", 64'({pe_clr_n, busy, act_rd}), 64'h4);
    for (int n = 1; n <= 5; n++) begin
      chk($sformatf("t6_idle_c%0d", n), 64'({result_valid, busy, act_rd, error}), 64'h0);
      tick();
    end

`ifdef FC_FEEDER_TIMEOUT_EN
    // Watchdog: pe_done never rises, error 16 cycles into DRAIN
    launch(8'd1, 32'h0);
    for (int n = 1; n <= 20; n++) begin
      chk($sformatf("tto_c%0d", n), 64'({error, busy, result_valid}),
          64'({(n == 19), (n <= 18), 1'b0}));
      tick();
    end
    chk("tto_result", 64'(result), 64'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
